// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: owns the PC, runs one SRAM-like fetch at a time and
// presents {pc, inst} to IF/ID, honouring stall, flush and delayed branch redirects.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        adel_o,
    output logic        stallreq_from_if
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        adel_buf_q, adel_buf_d;
    logic        discard_q, discard_d;
    logic        misaligned;

    assign misaligned = (req_addr_q[1:0] != 2'b00);

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_buf_d = inst_buf_q;
        adel_buf_d = adel_buf_q;
        discard_d  = discard_q;

        case (state_q)
            ST_REQ: begin
                if (misaligned) begin
                    // A misaligned PC never reaches the bus; a flush simply retargets it.
                    if (flush) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_DONE;
                        inst_buf_d = 32'h0000_0000;
                        adel_buf_d = 1'b1;
                    end
                end else begin
                    if (inst_addr_ok) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                    discard_d = discard_q | flush;
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (discard_q || flush) begin
                        state_d   = ST_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = ST_DONE;
                        inst_buf_d = inst_rdata;
                        adel_buf_d = 1'b0;
                    end
                end else begin
                    discard_d = discard_q | flush;
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d = ST_REQ;
                end else if (!stall[0]) begin
                    // Branch seen in ID now belongs to the slot just delivered (delay slot).
                    state_d = ST_REQ;
                    pc_d    = branch_flag_i ? branch_target_i : (req_addr_q + 32'd4);
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (flush) begin
            pc_d = new_pc;
        end else begin
            pc_d = pc_d;
        end

        // Latch the fetch address whenever a fresh request phase begins.
        if ((state_d == ST_REQ) && ((state_q != ST_REQ) || misaligned)) begin
            req_addr_d = pc_d;
        end else begin
            req_addr_d = req_addr_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_buf_q <= 32'h0000_0000;
            adel_buf_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_buf_q <= inst_buf_d;
            adel_buf_q <= adel_buf_d;
            discard_q  <= discard_d;
        end
    end

    assign inst_req         = !rst && (state_q == ST_REQ) && !misaligned;
    assign inst_addr        = req_addr_q;
    assign pc_o             = req_addr_q;
    assign inst_o           = inst_buf_q;
    assign adel_o           = adel_buf_q;
    assign stallreq_from_if = !rst && (state_q != ST_DONE);

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the MIPS pipeline. Owns the PC, issues fetches on the SRAM-like instruction port (bridged to AXI elsewhere) and hands {pc, inst} to the IF/ID register.
- Drives stallreq_from_if into the pipeline controller while a fetch is outstanding.
- Consumes the controller's stall, flush and new_pc outputs.
- Honours ID-stage branch redirects with MIPS delay-slot semantics.

Parameters:
RESET_PC, 32'hBFC00000, PC loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  6  controller stall vector; stall[0] freezes PC advance.
flush  in  1  controller flush; redirect to new_pc.
new_pc  in  32  exception/eret target, valid when flush=1.
branch_flag_i  in  1  ID-stage taken branch/jump.
branch_target_i  in  32  branch target.
inst_req  out  1  instruction request.
inst_addr  out  32  request address; stable while inst_req=1 and not yet accepted.
inst_addr_ok  in  1  address accepted this cycle.
inst_data_ok  in  1  read data valid this cycle.
inst_rdata  in  32  read data.
pc_o  out  32  PC of delivered instruction.
inst_o  out  32  delivered instruction.
adel_o  out  1  delivered slot carries an address-error (fetch) exception.
stallreq_from_if  out  1  fetch not complete.

Behaviour:
- Registers: state {REQ, WAIT_DATA, DONE}, pc (next fetch PC), req_addr, inst_buf, adel_buf, discard.
- Reset (rst=1 at edge) puts every register in a known value:
  - state=REQ, pc=RESET_PC, req_addr=RESET_PC, inst_buf=0, adel_buf=0, discard=0.
  - While rst=1: inst_req=0, stallreq_from_if=0.
  - After reset: pc_o=RESET_PC, inst_o=0, adel_o=0.
- Outputs:
  - inst_req=(state==REQ), inst_addr=req_addr.
  - pc_o=req_addr, inst_o=inst_buf, adel_o=adel_buf.
  - stallreq_from_if=(state!=DONE).
- REQ:
  - On entry, req_addr=pc.
  - If pc[1:0]!=0: no request; next cycle DONE with inst_buf=0, adel_buf=1.
  - Otherwise hold inst_req=1 until inst_addr_ok, then WAIT_DATA.
- WAIT_DATA:
  - On inst_data_ok with discard=0: inst_buf<=inst_rdata, adel_buf<=0, go DONE.
  - On inst_data_ok with discard=1: drop data, clear discard, go REQ.
- DONE: instruction presented.
  - If stall[0]=0: pc<=branch_flag_i ? branch_target_i : req_addr+4 (mod 2^32), go REQ.
  - If stall[0]=1: hold everything.
- Delay slot: the branch is seen in ID while its delay slot is being fetched, so the target is applied after the delay slot is delivered.
- flush=1 has priority over all of the above:
  - pc<=new_pc.
  - In DONE: go REQ.
  - In REQ with no inst_addr_ok: request stays asserted with the old address, and discard<=1.
  - In REQ with inst_addr_ok the same cycle: go WAIT_DATA, discard<=1.
  - In WAIT_DATA with inst_data_ok the same cycle: drop data, go REQ.
  - In WAIT_DATA otherwise: discard<=1.
- Discarded REQ: when an address is accepted with discard set, it proceeds to WAIT_DATA, drops the data and refetches pc.
- Repeated flushes while discard=1 only update pc.
- At most one transaction outstanding; minimum 3 cycles per instruction (REQ→WAIT_DATA→DONE).
- Mid-operation reset: the bus bridge shares rst, so no stale data_ok arrives after reset; the FSM restarts at REQ.

Test Plan:
- Reset then zero-wait memory returning 0x24010001, 0x24020002: addr 0xBFC00000 then 0xBFC00004; pc_o/inst_o each held in DONE with stallreq_from_if=0 for one cycle; 3-cycle cadence.
- Branch: DONE with pc_o=0xBFC00004 and branch_flag_i=1, target 0xBFC00100 → next inst_addr=0xBFC00100.
- stall[0]=1 for 4 cycles in DONE: no new inst_req; pc_o/inst_o stable.
- Flush (new_pc=0xBFC00380) during WAIT_DATA for 0xBFC00010: data 0xDEADBEEF dropped; next inst_addr=0xBFC00380; inst_o never shows 0xDEADBEEF.
- Flush coincident with inst_addr_ok, data_ok delayed 3 cycles: data discarded; then fetch of new_pc; no second outstanding request.
- new_pc=0xBFC00382 via flush: no inst_req; DONE with adel_o=1, inst_o=0, pc_o=0xBFC00382.
- rst asserted mid-WAIT_DATA: next cycle inst_addr=0xBFC00000, discard=0, inst_req=1.
